// File: rtl/bringup_sequencer.sv
// Board bring-up reset sequencer: MMCM lock -> DDR reset/calibration ->
// PCIe link -> core release, with timeout/retry and a sticky FAIL state.
// Ports: clock, sys_rst_l (sync, active-low), mmcm_locked, ddr_calib_done,
//   pcie_link_up (async, synchronized here), sw_restart (sync level);
//   ddr_rst, pcie_rst_l, core_reset, led[3:0] = {error, state}, retry_cnt[1:0].
// Build option: `define BRINGUP_PCIE_EN adds the PCIE_WAIT stage; without it
//   DDR_CAL goes straight to RELEASE and pcie_rst_l stays asserted.
module bringup_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clock,
    input  logic       sys_rst_l,
    input  logic       mmcm_locked,
    input  logic       ddr_calib_done,
    input  logic       pcie_link_up,
    input  logic       sw_restart,
    output logic       ddr_rst,
    output logic       pcie_rst_l,
    output logic       core_reset,
    output logic [3:0] led,
    output logic [1:0] retry_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MMCM_WAIT = 3'd1;
    localparam logic [2:0] S_DDR_RST   = 3'd2;
    localparam logic [2:0] S_DDR_CAL   = 3'd3;
    localparam logic [2:0] S_PCIE_WAIT = 3'd4;
    localparam logic [2:0] S_RELEASE   = 3'd5;
    localparam logic [2:0] S_RUN       = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    localparam logic [23:0] HOLD_LD   = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] TMO_LD    = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

`ifdef BRINGUP_PCIE_EN
    localparam logic [2:0] S_AFTER_CAL = S_PCIE_WAIT;
`else
    localparam logic [2:0] S_AFTER_CAL = S_RELEASE;
`endif

    logic [1:0]  lock_sync;
    logic [1:0]  cal_sync;
    logic        lock_ok;
    logic        cal_ok;
    logic        link_ok;

    logic [2:0]  state;
    logic [2:0]  nxt_state;
    logic [23:0] cnt;
    logic [23:0] cnt_ld;
    logic [1:0]  retry_q;
    logic [1:0]  nxt_retry;
    logic        err_q;
    logic        nxt_err;
    logic        restart;
    logic        cnt_zero;
    logic        retry_ok;
    logic        past_mmcm;
    logic [2:0]  fail_state;
    logic [1:0]  fail_retry;
    logic        pcie_rel;

    always_ff @(posedge clock) begin
        if (!sys_rst_l) begin
            lock_sync <= '0;
            cal_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[0], mmcm_locked};
            cal_sync  <= {cal_sync[0], ddr_calib_done};
        end
    end

    assign lock_ok = lock_sync[1];
    assign cal_ok  = cal_sync[1];

`ifdef BRINGUP_PCIE_EN
    logic [1:0] link_sync;

    always_ff @(posedge clock) begin
        if (!sys_rst_l) begin
            link_sync <= '0;
        end else begin
            link_sync <= {link_sync[0], pcie_link_up};
        end
    end

    assign link_ok  = link_sync[1];
    assign pcie_rel = (state == S_PCIE_WAIT) || (state == S_RELEASE) ||
                      (state == S_RUN);
`else
    // Link status is meaningless without the PCIe stage.
    logic unused_link;
    assign unused_link = pcie_link_up;
    assign link_ok     = 1'b1;
    assign pcie_rel    = 1'b0;
`endif

    assign past_mmcm = (state != S_IDLE) && (state != S_MMCM_WAIT);
    assign cnt_zero  = (cnt == '0);
    assign retry_ok  = (retry_q < RETRY_MAX);

    // Where a timeout or a dropped link in RUN lands: retry or give up.
    assign fail_state = retry_ok ? S_DDR_RST : S_FAIL;
    assign fail_retry = retry_ok ? retry_q + 2'd1 : retry_q;

    always_comb begin
        nxt_state = state;
        nxt_retry = retry_q;
        nxt_err   = err_q;
        restart   = 1'b0;
        if (past_mmcm && !lock_ok) begin
            nxt_state = S_MMCM_WAIT;
        end else if (past_mmcm && sw_restart) begin
            nxt_state = S_DDR_RST;
            nxt_retry = '0;
            nxt_err   = 1'b0;
            restart   = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: nxt_state = S_MMCM_WAIT;
                S_MMCM_WAIT: if (lock_ok) nxt_state = S_DDR_RST;
                S_DDR_RST: if (cnt_zero) nxt_state = S_DDR_CAL;
                // Arrival wins over an expiring counter in the same cycle.
                S_DDR_CAL: begin
                    if (cal_ok) begin
                        nxt_state = S_AFTER_CAL;
                    end else if (cnt_zero) begin
                        nxt_state = fail_state;
                        nxt_retry = fail_retry;
                        nxt_err   = err_q | ~retry_ok;
                    end
                end
`ifdef BRINGUP_PCIE_EN
                S_PCIE_WAIT: begin
                    if (link_ok) begin
                        nxt_state = S_RELEASE;
                    end else if (cnt_zero) begin
                        nxt_state = fail_state;
                        nxt_retry = fail_retry;
                        nxt_err   = err_q | ~retry_ok;
                    end
                end
`endif
                S_RELEASE: if (cnt_zero) nxt_state = S_RUN;
                S_RUN: begin
                    if (!cal_ok || !link_ok) begin
                        nxt_state = fail_state;
                        nxt_retry = fail_retry;
                        nxt_err   = 1'b1;
                    end
                end
                S_FAIL: nxt_state = S_FAIL;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        unique case (nxt_state)
            S_DDR_RST, S_RELEASE:   cnt_ld = HOLD_LD;
            S_DDR_CAL, S_PCIE_WAIT: cnt_ld = TMO_LD;
            default:                cnt_ld = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!sys_rst_l) begin
            state      <= S_IDLE;
            cnt        <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            ddr_rst    <= 1'b1;
            pcie_rst_l <= 1'b0;
            core_reset <= 1'b1;
            led        <= 4'b0000;
            retry_cnt  <= '0;
        end else begin
            state   <= nxt_state;
            retry_q <= nxt_retry;
            err_q   <= nxt_err;
            // sw_restart in DDR_RST re-enters the same state: reload too.
            if (restart || (nxt_state != state)) begin
                cnt <= cnt_ld;
            end else if (!cnt_zero) begin
                cnt <= cnt - 24'd1;
            end
            ddr_rst    <= (state == S_IDLE) || (state == S_MMCM_WAIT) ||
                          (state == S_DDR_RST);
            pcie_rst_l <= pcie_rel;
            core_reset <= (state != S_RUN);
            led        <= {err_q, state};
            retry_cnt  <= retry_q;
        end
    end

endmodule

// File: tb/tb_bringup_sequencer.sv
// Directed bench for bringup_sequencer (HOLD=4, TIMEOUT=100, MAX_RETRY=2).
// Adapts expected post-calibration state to the BRINGUP_PCIE_EN build.
module tb_bringup_sequencer;

`ifdef BRINGUP_PCIE_EN
    localparam bit PCIE = 1'b1;
`else
    localparam bit PCIE = 1'b0;
`endif
    localparam logic [2:0] POST_CAL = PCIE ? 3'd4 : 3'd5;

    logic       clock;
    logic       sys_rst_l;
    logic       mmcm_locked;
    logic       ddr_calib_done;
    logic       pcie_link_up;
    logic       sw_restart;
    logic       ddr_rst;
    logic       pcie_rst_l;
    logic       core_reset;
    logic [3:0] led;
    logic [1:0] retry_cnt;

    int checks = 0;
    int passes = 0;

    bringup_sequencer #(
        .HOLD_CYCLES(4),
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY(2)
    ) dut (
        .clock(clock),
        .sys_rst_l(sys_rst_l),
        .mmcm_locked(mmcm_locked),
        .ddr_calib_done(ddr_calib_done),
        .pcie_link_up(pcie_link_up),
        .sw_restart(sw_restart),
        .ddr_rst(ddr_rst),
        .pcie_rst_l(pcie_rst_l),
        .core_reset(core_reset),
        .led(led),
        .retry_cnt(retry_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Tick until the visible state code changes; k = ticks taken.
    task automatic wait_change(input int max, output int k, output logic [2:0] nu);
        logic [2:0] cur;
        cur = led[2:0];
        k = 0;
        do begin
            tick();
            k++;
        end while (led[2:0] == cur && k < max);
        nu = led[2:0];
    endtask

    task automatic do_reset();
        sys_rst_l      = 1'b0;
        mmcm_locked    = 1'b0;
        ddr_calib_done = 1'b0;
        pcie_link_up   = 1'b0;
        sw_restart     = 1'b0;
        repeat (3) tick();
        sys_rst_l = 1'b1;
    endtask

    task automatic go_run();
        int n;
        do_reset();
        mmcm_locked    = 1'b1;
        ddr_calib_done = 1'b1;
        pcie_link_up   = 1'b1;
        n = 0;
        while (led[2:0] != 3'd6 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        sys_rst_l      = 1'b0;
        mmcm_locked    = 1'($urandom);
        ddr_calib_done = 1'($urandom);
        pcie_link_up   = 1'($urandom);
        sw_restart     = 1'($urandom);
        repeat (3) tick();
        checks++; if (ddr_rst !== 1'b1) $display("FAIL rst_ddr_rst: got %b want 1", ddr_rst); else passes++;
        checks++; if (pcie_rst_l !== 1'b0) $display("FAIL rst_pcie_rst_l: got %b want 0", pcie_rst_l); else passes++;
        checks++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: got %b want 1", core_reset); else passes++;
        checks++; if (led !== 4'b0000) $display("FAIL rst_led: got %b want 0000", led); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL rst_retry: got %0d want 0", retry_cnt); else passes++;
        mmcm_locked    = 1'b0;
        ddr_calib_done = 1'b0;
        pcie_link_up   = 1'b0;
        sw_restart     = 1'b0;
        sys_rst_l      = 1'b1;
        tick();
        checks++; if (led !== 4'b0000) $display("FAIL rst_idle_led: got %b want 0000", led); else passes++;
        tick();
        checks++; if (led !== 4'b0001) $display("FAIL rst_mmcm_led: got %b want 0001", led); else passes++;
        repeat (5) tick();
        checks++; if (led !== 4'b0001) $display("FAIL rst_no_lock: got %b want 0001", led); else passes++;
    endtask

    task automatic test_nominal();
        int k;
        logic [2:0] nu;
        do_reset();
        mmcm_locked = 1'b1;
        wait_change(10, k, nu);
        checks++; if (nu !== 3'd1) $display("FAIL nom_s1: got %0d want 1", nu); else passes++;
        wait_change(10, k, nu);
        checks++; if (nu !== 3'd2) $display("FAIL nom_s2: got %0d want 2", nu); else passes++;
        checks++; if (ddr_rst !== 1'b1) $display("FAIL nom_ddr_rst_hi: got %b want 1", ddr_rst); else passes++;
        wait_change(20, k, nu);
        checks++; if (nu !== 3'd3) $display("FAIL nom_s3: got %0d want 3", nu); else passes++;
        checks++; if (k !== 4) $display("FAIL nom_hold: got %0d want 4", k); else passes++;
        checks++; if (ddr_rst !== 1'b0) $display("FAIL nom_ddr_rst_lo: got %b want 0", ddr_rst); else passes++;
        repeat (10) tick();
        ddr_calib_done = 1'b1;
        wait_change(20, k, nu);
        checks++; if (nu !== POST_CAL) $display("FAIL nom_post_cal: got %0d want %0d", nu, POST_CAL); else passes++;
        checks++; if (pcie_rst_l !== PCIE) $display("FAIL nom_pcie_rst_l: got %b want %b", pcie_rst_l, PCIE); else passes++;
        pcie_link_up = 1'b1;
`ifdef BRINGUP_PCIE_EN
        wait_change(20, k, nu);
`endif
        checks++; if (led[2:0] !== 3'd5) $display("FAIL nom_s5: got %0d want 5", led[2:0]); else passes++;
        checks++; if (core_reset !== 1'b1) $display("FAIL nom_rel_core: got %b want 1", core_reset); else passes++;
        wait_change(20, k, nu);
        checks++; if (nu !== 3'd6) $display("FAIL nom_s6: got %0d want 6", nu); else passes++;
        checks++; if (k !== 4) $display("FAIL nom_rel_hold: got %0d want 4", k); else passes++;
        checks++; if (led !== 4'b0110) $display("FAIL nom_led: got %b want 0110", led); else passes++;
        checks++; if (core_reset !== 1'b0) $display("FAIL nom_core: got %b want 0", core_reset); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL nom_retry: got %0d want 0", retry_cnt); else passes++;
        checks++; if (pcie_rst_l !== PCIE) $display("FAIL nom_run_pcie: got %b want %b", pcie_rst_l, PCIE); else passes++;
    endtask

    task automatic test_lock_loss();
        int k;
        logic [2:0] nu;
        go_run();
        mmcm_locked = 1'b0;
        wait_change(10, k, nu);
        checks++; if (nu !== 3'd1) $display("FAIL lock_state: got %0d want 1", nu); else passes++;
        checks++; if (k !== 4) $display("FAIL lock_latency: got %0d want 4", k); else passes++;
        checks++; if (core_reset !== 1'b1) $display("FAIL lock_core: got %b want 1", core_reset); else passes++;
        checks++; if (ddr_rst !== 1'b1) $display("FAIL lock_ddr: got %b want 1", ddr_rst); else passes++;
        mmcm_locked = 1'b1;
        wait_change(10, k, nu);
        checks++; if (nu !== 3'd2) $display("FAIL lock_relock: got %0d want 2", nu); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL lock_retry: got %0d want 0", retry_cnt); else passes++;
    endtask

    task automatic test_timeout_fail();
        int k;
        logic [2:0] nu;
        do_reset();
        mmcm_locked = 1'b1;
        wait_change(10, k, nu);
        wait_change(10, k, nu);
        wait_change(20, k, nu);
        for (int r = 1; r <= 2; r++) begin
            wait_change(200, k, nu);
            checks++; if (k !== 100) $display("FAIL tmo%0d_len: got %0d want 100", r, k); else passes++;
            checks++; if (nu !== 3'd2) $display("FAIL tmo%0d_state: got %0d want 2", r, nu); else passes++;
            checks++; if (retry_cnt !== 2'(r)) $display("FAIL tmo%0d_retry: got %0d want %0d", r, retry_cnt, r); else passes++;
            wait_change(20, k, nu);
        end
        wait_change(200, k, nu);
        checks++; if (k !== 100) $display("FAIL tmo3_len: got %0d want 100", k); else passes++;
        checks++; if (led !== 4'b1111) $display("FAIL tmo_fail_led: got %b want 1111", led); else passes++;
        checks++; if (pcie_rst_l !== 1'b0) $display("FAIL tmo_fail_pcie: got %b want 0", pcie_rst_l); else passes++;
        checks++; if (retry_cnt !== 2'd2) $display("FAIL tmo_fail_retry: got %0d want 2", retry_cnt); else passes++;
        repeat (20) tick();
        checks++; if (led !== 4'b1111) $display("FAIL fail_sticky: got %b want 1111", led); else passes++;
    endtask

    task automatic test_sw_restart();
        int k;
        logic [2:0] nu;
        sw_restart = 1'b1;
        tick();
        sw_restart = 1'b0;
        wait_change(10, k, nu);
        checks++; if (k !== 1) $display("FAIL swr_latency: got %0d want 1", k); else passes++;
        checks++; if (led !== 4'b0010) $display("FAIL swr_led: got %b want 0010", led); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL swr_retry: got %0d want 0", retry_cnt); else passes++;
    endtask

    task automatic test_boundary();
        int k;
        logic [2:0] nu;
        do_reset();
        mmcm_locked = 1'b1;
        wait_change(10, k, nu);
        wait_change(10, k, nu);
        wait_change(20, k, nu);
        repeat (96) tick();
        ddr_calib_done = 1'b1;
        wait_change(20, k, nu);
        checks++; if (k !== 4) $display("FAIL bnd_len: got %0d want 4", k); else passes++;
        checks++; if (nu !== POST_CAL) $display("FAIL bnd_state: got %0d want %0d", nu, POST_CAL); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL bnd_retry: got %0d want 0", retry_cnt); else passes++;
    endtask

    task automatic test_run_loss();
        int k;
        logic [2:0] nu;
        go_run();
        ddr_calib_done = 1'b0;
        wait_change(10, k, nu);
        checks++; if (k !== 4) $display("FAIL loss_latency: got %0d want 4", k); else passes++;
        checks++; if (led !== 4'b1010) $display("FAIL loss_led: got %b want 1010", led); else passes++;
        checks++; if (retry_cnt !== 2'd1) $display("FAIL loss_retry: got %0d want 1", retry_cnt); else passes++;
    endtask

    task automatic test_reset_midseq();
        int k;
        logic [2:0] nu;
        pcie_link_up   = 1'b0;
        ddr_calib_done = 1'b1;
        wait_change(20, k, nu);
        wait_change(20, k, nu);
        checks++; if (nu !== POST_CAL) $display("FAIL mid_state: got %0d want %0d", nu, POST_CAL); else passes++;
        checks++; if (pcie_rst_l !== PCIE) $display("FAIL mid_pcie_pre: got %b want %b", pcie_rst_l, PCIE); else passes++;
        sys_rst_l = 1'b0;
        tick();
        checks++; if (ddr_rst !== 1'b1) $display("FAIL mid_ddr_rst: got %b want 1", ddr_rst); else passes++;
        checks++; if (pcie_rst_l !== 1'b0) $display("FAIL mid_pcie_rst_l: got %b want 0", pcie_rst_l); else passes++;
        checks++; if (core_reset !== 1'b1) $display("FAIL mid_core: got %b want 1", core_reset); else passes++;
        checks++; if (led !== 4'b0000) $display("FAIL mid_led: got %b want 0000", led); else passes++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL mid_retry: got %0d want 0", retry_cnt); else passes++;
        sys_rst_l = 1'b1;
    endtask

    initial begin
        sys_rst_l      = 1'b0;
        mmcm_locked    = 1'b0;
        ddr_calib_done = 1'b0;
        pcie_link_up   = 1'b0;
        sw_restart     = 1'b0;
        test_reset();
        test_nominal();
        test_lock_loss();
        test_timeout_fail();
        test_sw_restart();
        test_boundary();
        test_run_loss();
        test_reset_midseq();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
